// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - requester ports and SDRAM controller strobes for sdram_arbiter
// slave = arbiter view; master = requester/controller side (testbench or surrounding logic).
interface sdram_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [25:0] p0_addr;
  logic [7:0]  p0_wdata;
  logic        p0_ack;
  logic        p0_err;
  logic [7:0]  p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [25:0] p1_addr;
  logic [7:0]  p1_wdata;
  logic        p1_ack;
  logic        p1_err;
  logic [7:0]  p1_rdata;

  logic        mem_mreq;
  logic        mem_read;
  logic        mem_write;
  logic [25:0] mem_address;
  logic [7:0]  mem_in;
  logic        mem_ce;
  logic [7:0]  mem_out;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_ce, mem_out,
    output p0_ack, p0_err, p0_rdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_mreq, mem_read, mem_write, mem_address, mem_in
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_ce, mem_out,
    input  p0_ack, p0_err, p0_rdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_mreq, mem_read, mem_write, mem_address, mem_in
  );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port SDRAM request arbiter with acceptance timeout
// Round-robin grant by default; define SDRAM_ARB_P1_PRIORITY_EN for fixed port1-over-port0 priority.
module sdram_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic            clock,
  input logic            reset_n,
  sdram_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_gnt;
  logic        r_mem_mreq;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [25:0] r_mem_address;
  logic [7:0]  r_mem_in;
  logic        r_p0_ack;
  logic        r_p0_err;
  logic [7:0]  r_p0_rdata;
  logic        r_p1_ack;
  logic        r_p1_err;
  logic [7:0]  r_p1_rdata;

  logic        w_any_req;
  logic        w_ack_now;
  logic        w_gnt;
  logic        w_sel_we;
  logic [25:0] w_sel_addr;
  logic [7:0]  w_sel_wdata;

  assign w_any_req = bus.p0_req | bus.p1_req;
  // Ack still high means the requester has not yet seen completion: leave a 1-cycle gap.
  assign w_ack_now = r_p0_ack | r_p1_ack;

`ifdef SDRAM_ARB_P1_PRIORITY_EN
  assign w_gnt = bus.p1_req;
`else
  logic r_last;
  assign w_gnt = (bus.p0_req & bus.p1_req) ? ~r_last : bus.p1_req;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (r_state == S_WAIT && bus.mem_ce) begin
      r_last <= r_gnt;
    end
  end
`endif

  assign w_sel_we    = w_gnt ? bus.p1_we    : bus.p0_we;
  assign w_sel_addr  = w_gnt ? bus.p1_addr  : bus.p0_addr;
  assign w_sel_wdata = w_gnt ? bus.p1_wdata : bus.p0_wdata;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_gnt         <= 1'b0;
      r_mem_mreq    <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= 26'd0;
      r_mem_in      <= 8'd0;
      r_p0_ack      <= 1'b0;
      r_p0_err      <= 1'b0;
      r_p0_rdata    <= 8'd0;
      r_p1_ack      <= 1'b0;
      r_p1_err      <= 1'b0;
      r_p1_rdata    <= 8'd0;
    end else begin
      r_p0_ack <= 1'b0;
      r_p0_err <= 1'b0;
      r_p1_ack <= 1'b0;
      r_p1_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req && !w_ack_now) begin
            r_gnt         <= w_gnt;
            r_mem_address <= w_sel_addr;
            r_mem_in      <= w_sel_wdata;
            r_mem_mreq    <= 1'b1;
            r_mem_read    <= ~w_sel_we;
            r_mem_write   <= w_sel_we;
            r_cnt         <= 8'd0;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!bus.mem_ce) begin
            r_state <= S_WAIT;
          end else if (r_cnt == LP_TIMEOUT) begin
            // Controller never accepted: abort with error, read data left untouched.
            r_mem_mreq  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_gnt) begin
              r_p1_ack <= 1'b1;
              r_p1_err <= 1'b1;
            end else begin
              r_p0_ack <= 1'b1;
              r_p0_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (bus.mem_ce) begin
            r_mem_mreq  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_gnt) begin
              r_p1_ack <= 1'b1;
              if (!r_mem_write) r_p1_rdata <= bus.mem_out;
            end else begin
              r_p0_ack <= 1'b1;
              if (!r_mem_write) r_p0_rdata <= bus.mem_out;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_mreq    = r_mem_mreq;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_in      = r_mem_in;
  assign bus.p0_ack      = r_p0_ack;
  assign bus.p0_err      = r_p0_err;
  assign bus.p0_rdata    = r_p0_rdata;
  assign bus.p1_ack      = r_p1_ack;
  assign bus.p1_err      = r_p1_err;
  assign bus.p1_rdata    = r_p1_rdata;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max clocks in ISSUE waiting for controller acceptance; range 1..255.
REQ-002 SHALL have port clock, input, 1: 50 MHz system clock; all logic on posedge.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port p0_req, input, 1: CPU port request, held until p0_ack.
REQ-005 SHALL have port p0_we, input, 1: CPU port; 1 = write, 0 = read.
REQ-006 SHALL have port p0_addr, input, 26: CPU port byte address.
REQ-007 SHALL have port p0_wdata, input, 8: CPU port write byte.
REQ-008 SHALL have ports p0_ack (output, 1), p0_err (output, 1) and p0_rdata (output, 8): CPU port completion pulse, timeout flag and read byte.
REQ-009 SHALL have ports p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err and p1_rdata: video/DMA port, identical widths and meanings to port 0.
REQ-010 SHALL have ports mem_mreq, mem_read and mem_write (each output, 1): request strobes to the SDRAM controller.
REQ-011 SHALL have ports mem_address (output, 26) and mem_in (output, 8): controller address and write byte.
REQ-012 SHALL have ports mem_ce (input, 1) and mem_out (input, 8): controller ready (low = busy) and read byte.

Function
REQ-013 SHALL implement FSM with states IDLE, ISSUE, WAIT; the state register SHALL be 2 bits.
REQ-014 IDLE: if any pN_req is high and no ack is asserted this cycle, the block SHALL select a grant, latch addr/we/wdata into mem_* registers, and set mem_mreq=1, mem_read=~we, mem_write=we.
    - Then go to ISSUE and clear the timeout counter.
REQ-015 Grant SHALL be round-robin: the port not granted last wins a simultaneous request; a single requester always wins.
REQ-016 ISSUE: on mem_ce==0 (controller accepted) the block SHALL go to WAIT, with mem_* held stable.
REQ-017 ISSUE: the timeout counter SHALL increment each cycle; when it equals TIMEOUT with mem_ce still 1, the block SHALL abort.
    - Abort action: clear mem_mreq/read/write, pulse granted ack with err=1, rdata unchanged, go to IDLE.
REQ-018 WAIT: on mem_ce==1 the block SHALL complete.
    - Clear mem_mreq/read/write.
    - For reads, register mem_out into granted pN_rdata.
    - Pulse granted pN_ack for exactly one cycle with pN_err=0, update the last-grant pointer, go to IDLE.
REQ-019 WAIT SHALL have no timeout; the controller always completes once it has accepted.
REQ-020 ack SHALL be registered; it is high in the first IDLE cycle after completion, and no new grant SHALL be made in that cycle (1-cycle gap).
REQ-021 A requester still holding req in the cycle after ack SHALL be treated as issuing a new request.
REQ-022 pN_err SHALL be valid only while pN_ack=1 and zero otherwise; pN_rdata SHALL hold its value until the next read completion on that port.
REQ-023 Requests arriving on either port in ISSUE/WAIT SHALL be ignored until IDLE; requester inputs SHALL NOT be resampled mid-transaction.
REQ-024 Latency, uncontended read: grant +1 clock after req; ack +1 clock after mem_ce rises in WAIT.

Reset
REQ-025 On reset_n==0 at posedge: state=IDLE, counter=0, last-grant=port1 (port0 wins first tie), all acks/errs=0, mem_mreq/read/write=0, mem_address=0, mem_in=0, p0_rdata=p1_rdata=0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction without ack; the controller's own reset covers the SDRAM side.

Configuration
REQ-027 With macro SDRAM_ARB_P1_PRIORITY_EN defined, grant SHALL be fixed priority, port1 over port0, and the last-grant pointer SHALL be unused.
REQ-028 With SDRAM_ARB_P1_PRIORITY_EN undefined, grant SHALL be round-robin per REQ-015.

Verification
REQ-029 Single read: p0 read 0x0000123, controller holds mem_ce=0 for 8 clocks, mem_out=0x5A -> mem_read=1 at addr 0x0000123; p0_ack one cycle, p0_rdata=0x5A, p0_err=0.
REQ-030 Single write: p1 write 0x3FFFFFF data 0xA5 -> mem_write=1, mem_in=0xA5, mem_read=0; p1_ack after mem_ce returns high; p1_rdata unchanged.
REQ-031 Tie: p0 and p1 both request from reset, both held -> grant order p0, p1, p0, p1 with 1-cycle IDLE gap after each ack; with SDRAM_ARB_P1_PRIORITY_EN: p1 repeatedly, p0 starved.
REQ-032 Timeout: TIMEOUT=4, mem_ce stuck at 1 -> mem_mreq drops and p0_ack=1 with p0_err=1 exactly 5 clocks after grant; the next request is served normally.
REQ-033 Reset mid-WAIT: reset_n low for one clock during WAIT -> no ack, all outputs at reset values next cycle, a subsequent p0 read completes normally.
REQ-034 Refresh stall: mem_ce low for 406 clocks while in ISSUE is accepted only when it falls -> TIMEOUT counter stops in WAIT, completion without err.
